// File: rtl/div_nbit_rv.sv
// div_nbit_rv: iterative restoring radix-2 divider with RISC-V DIV/DIVU/REM/REMU
// semantics, request tag and back-pressured result handshake.
// Optional build macro: DIV_EARLY_OUT_EN (leading-zero based early-out iteration count).
module div_nbit_rv #(
   parameter int SIZE  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             ready,
   input  logic             is_signed,
   input  logic [TAG_W-1:0] tag,
   input  logic [SIZE-1:0]  dividend,
   input  logic [SIZE-1:0]  divisor,
   output logic             valid,
   input  logic             out_ready,
   output logic             error,
   output logic             overflow,
   output logic [SIZE-1:0]  quotient,
   output logic [SIZE-1:0]  remainder,
   output logic [TAG_W-1:0] tag_out
);

   localparam int CW = $clog2(SIZE + 1);
   localparam logic [SIZE-1:0] ONE     = {{(SIZE-1){1'b0}}, 1'b1};
   localparam logic [SIZE-1:0] MIN_VAL = {1'b1, {(SIZE-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      DIVIDE,
      FIXUP,
      DONE
   } state_t;

   state_t state, state_next;

   // captured request
   logic            signed_r;
   logic            neg_n;
   logic            neg_d;
   logic [SIZE-1:0] raw_n;
   logic [SIZE-1:0] abs_n;
   logic [SIZE-1:0] abs_d;

   // working registers; quo/rem double as the result registers
   logic [SIZE-1:0]   quo;
   logic [SIZE-1:0]   rem;
   logic [SIZE-1:0]   cnt;
   logic [2*SIZE-1:0] sdiv;

   // combinational helpers
   logic              in_neg_n;
   logic              in_neg_d;
   logic [SIZE-1:0]   in_abs_n;
   logic [SIZE-1:0]   in_abs_d;
   logic              div_zero;
   logic              div_ovf;
   logic              too_small;
   logic              fits;
   logic              last;
   logic [2*SIZE-1:0] rem_ext;
   logic [CW-1:0]     shamt;

   assign ready     = (state == IDLE);
   assign valid     = (state == DONE);
   assign quotient  = quo;
   assign remainder = rem;

   // request decode, magnitude and special-case detection
   always_comb begin
      in_neg_n  = is_signed & dividend[SIZE-1];
      in_neg_d  = is_signed & divisor[SIZE-1];
      in_abs_n  = in_neg_n ? ('0 - dividend) : dividend;
      in_abs_d  = in_neg_d ? ('0 - divisor)  : divisor;
      div_zero  = (divisor == '0);
      div_ovf   = is_signed && (dividend == MIN_VAL) && (divisor == '1);
      too_small = (abs_d > abs_n);
      rem_ext   = {{SIZE{1'b0}}, rem};
      fits      = (rem_ext >= sdiv);
      last      = (cnt == ONE);
   end

`ifdef DIV_EARLY_OUT_EN
   function automatic logic [CW-1:0] lzc(input logic [SIZE-1:0] v);
      logic found;
      lzc   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < SIZE; i++) begin
         if (!found) begin
            if (v[SIZE-1-i]) found = 1'b1;
            else             lzc   = lzc + 1'b1;
         end
      end
   endfunction

   logic [CW-1:0] lzc_n;
   logic [CW-1:0] lzc_d;

   // shift = k-1 = lzc(|divisor|) - lzc(|dividend|); only used when |divisor| <= |dividend|
   always_comb begin
      lzc_n = lzc(abs_n);
      lzc_d = lzc(abs_d);
      shamt = lzc_d - lzc_n;
   end
`else
   // fixed full-width iteration count
   always_comb begin
      shamt = CW'(SIZE - 1);
   end
`endif

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (div_zero || div_ovf) state_next = DONE;
               else                     state_next = SETUP;
            end
         end
         SETUP:   state_next = too_small ? DONE : DIVIDE;
         DIVIDE:  state_next = last ? FIXUP : DIVIDE;
         FIXUP:   state_next = DONE;
         DONE:    state_next = out_ready ? IDLE : DONE;
         default: state_next = IDLE;
      endcase
   end

   // datapath: capture, setup, restoring iteration and sign fix-up
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         signed_r <= 1'b0;
         neg_n    <= 1'b0;
         neg_d    <= 1'b0;
         raw_n    <= '0;
         abs_n    <= '0;
         abs_d    <= '0;
         quo      <= '0;
         rem      <= '0;
         cnt      <= '0;
         sdiv     <= '0;
         error    <= 1'b0;
         overflow <= 1'b0;
         tag_out  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  tag_out  <= tag;
                  signed_r <= is_signed;
                  neg_n    <= in_neg_n;
                  neg_d    <= in_neg_d;
                  raw_n    <= dividend;
                  abs_n    <= in_abs_n;
                  abs_d    <= in_abs_d;
                  error    <= div_zero;
                  overflow <= ~div_zero & div_ovf;
                  if (div_zero) begin
                     quo <= '1;
                     rem <= dividend;
                  end else if (div_ovf) begin
                     quo <= dividend;
                     rem <= '0;
                  end
               end
            end
            SETUP: begin
               quo <= '0;
               if (too_small) begin
                  rem <= raw_n;
               end else begin
                  rem  <= abs_n;
                  sdiv <= {{SIZE{1'b0}}, abs_d} << shamt;
                  cnt  <= ONE << shamt;
               end
            end
            DIVIDE: begin
               if (fits) begin
                  rem <= rem - sdiv[SIZE-1:0];
                  quo <= quo | cnt;
               end
               sdiv <= sdiv >> 1;
               cnt  <= cnt >> 1;
            end
            FIXUP: begin
               if (signed_r) begin
                  if (neg_n ^ neg_d) quo <= '0 - quo;
                  if (neg_n)         rem <= '0 - rem;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_nbit_rv.sv
// tb_div_nbit_rv: table-driven directed vectors for div_nbit_rv (SIZE=32, TAG_W=4),
// plus back-pressure and reset-during-divide sequences.
module tb_div_nbit_rv;

   logic        clk;
   logic        reset;
   logic        start;
   logic        ready;
   logic        is_signed;
   logic [3:0]  tag;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        valid;
   logic        out_ready;
   logic        error;
   logic        overflow;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic [3:0]  tag_out;

   int n_vec;
   int miscompares;

   div_nbit_rv #(.SIZE(32), .TAG_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .ready     (ready),
      .is_signed (is_signed),
      .tag       (tag),
      .dividend  (dividend),
      .divisor   (divisor),
      .valid     (valid),
      .out_ready (out_ready),
      .error     (error),
      .overflow  (overflow),
      .quotient  (quotient),
      .remainder (remainder),
      .tag_out   (tag_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] n;
      logic [31:0] d;
      logic [3:0]  tg;
      logic [31:0] q;
      logic [31:0] r;
      logic        err;
      logic        ovf;
      int          lat_eo;
      int          lat_full;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
         miscompares++;
      end
   endtask

   task automatic launch(input vec_t v);
      @(negedge clk);
      start     = 1'b1;
      is_signed = v.sgn;
      dividend  = v.n;
      divisor   = v.d;
      tag       = v.tg;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // called right after the accepting edge (+1); returns edges counted incl. the accepting one
   task automatic wait_valid(input string name, output int lat);
      lat = 1;
      while (!valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!valid) begin
         $display("FAIL %s_timeout: got valid=0 after %0d edges, required valid=1", name, lat);
         miscompares++;
      end
   endtask

   task automatic handshake(input string name);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({name, "_ready_after"}, {31'd0, ready}, 32'd1);
      chk({name, "_valid_after"}, {31'd0, valid}, 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int    lat;
      int    exp_lat;
      string nm;
      nm = $sformatf("v%0d", idx);
      n_vec++;
`ifdef DIV_EARLY_OUT_EN
      exp_lat = v.lat_eo;
`else
      exp_lat = v.lat_full;
`endif
      chk({nm, "_ready_idle"}, {31'd0, ready}, 32'd1);
      launch(v);
      wait_valid(nm, lat);
      chk({nm, "_latency"},   lat,                 exp_lat);
      chk({nm, "_quotient"},  quotient,            v.q);
      chk({nm, "_remainder"}, remainder,           v.r);
      chk({nm, "_error"},     {31'd0, error},      {31'd0, v.err});
      chk({nm, "_overflow"},  {31'd0, overflow},   {31'd0, v.ovf});
      chk({nm, "_tag_out"},   {28'd0, tag_out},    {28'd0, v.tg});
      handshake(nm);
   endtask

   initial begin
      int   lat;
      vec_t big;

      //           sgn   dividend       divisor        tag   quotient       remainder     err   ovf  eo  full
      vecs[0]  = '{1'b0, 32'd100,       32'd7,         4'd5, 32'd14,        32'd2,        1'b0, 1'b0, 8, 35};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         4'd1, 32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0, 1'b0, 5, 35};
      vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  4'd2, 32'hFFFFFFFD,  32'd1,        1'b0, 1'b0, 5, 35};
      vecs[3]  = '{1'b0, 32'hFFFFFFF9,  32'd2,         4'd3, 32'h7FFFFFFC,  32'd1,        1'b0, 1'b0, 34, 35};
      vecs[4]  = '{1'b0, 32'd1234,      32'd0,         4'd4, 32'hFFFFFFFF,  32'd1234,     1'b1, 1'b0, 1, 1};
      vecs[5]  = '{1'b1, 32'd1234,      32'd0,         4'd6, 32'hFFFFFFFF,  32'd1234,     1'b1, 1'b0, 1, 1};
      vecs[6]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  4'd7, 32'h80000000,  32'd0,        1'b0, 1'b1, 1, 1};
      vecs[7]  = '{1'b0, 32'd3,         32'd10,        4'd8, 32'd0,         32'd3,        1'b0, 1'b0, 2, 2};
      vecs[8]  = '{1'b1, 32'hFFFFFFFD,  32'd10,        4'd9, 32'd0,         32'hFFFFFFFD, 1'b0, 1'b0, 2, 2};
      vecs[9]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  4'hA, 32'd0,         32'h80000000, 1'b0, 1'b0, 2, 2};
      vecs[10] = '{1'b0, 32'd10,        32'd10,        4'hB, 32'd1,         32'd0,        1'b0, 1'b0, 4, 35};
      vecs[11] = '{1'b1, 32'h80000000,  32'd2,         4'hC, 32'hC0000000,  32'd0,        1'b0, 1'b0, 34, 35};
      vecs[12] = '{1'b0, 32'd0,         32'd5,         4'hD, 32'd0,         32'd0,        1'b0, 1'b0, 2, 2};
      vecs[13] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  4'hE, 32'd14,        32'hFFFFFFFE, 1'b0, 1'b0, 8, 35};
      vecs[14] = '{1'b0, 32'hFFFFFFFF,  32'd1,         4'hF, 32'hFFFFFFFF,  32'd0,        1'b0, 1'b0, 35, 35};

      n_vec       = 0;
      miscompares = 0;
      reset       = 1'b1;
      start       = 1'b0;
      is_signed   = 1'b0;
      tag         = '0;
      dividend    = '0;
      divisor     = '0;
      out_ready   = 1'b0;

      // reset state
      #1;
      n_vec++;
      chk("rst_valid",     {31'd0, valid},    32'd0);
      chk("rst_ready",     {31'd0, ready},    32'd1);
      chk("rst_error",     {31'd0, error},    32'd0);
      chk("rst_overflow",  {31'd0, overflow}, 32'd0);
      chk("rst_quotient",  quotient,          32'd0);
      chk("rst_remainder", remainder,         32'd0);
      chk("rst_tag_out",   {28'd0, tag_out},  32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

      // back-pressure: result held, start ignored while valid
      n_vec++;
      launch(vecs[0]);
      wait_valid("bp", lat);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         start     = c[0];
         is_signed = 1'b0;
         dividend  = 32'd999;
         divisor   = 32'd3;
         tag       = 4'd0;
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_valid", c),     {31'd0, valid},   32'd1);
         chk($sformatf("bp%0d_ready", c),     {31'd0, ready},   32'd0);
         chk($sformatf("bp%0d_quotient", c),  quotient,         32'd14);
         chk($sformatf("bp%0d_remainder", c), remainder,        32'd2);
         chk($sformatf("bp%0d_tag_out", c),   {28'd0, tag_out}, 32'd5);
      end
      @(negedge clk);
      start = 1'b0;
      handshake("bp");
      @(posedge clk);
      #1;
      chk("bp_no_queued_start", {31'd0, ready}, 32'd1);

      // reset while in DIVIDE
      n_vec++;
      big = vecs[14];
      launch(big);
      repeat (4) @(posedge clk);
      #2;
      chk("mid_in_divide", {31'd0, ready}, 32'd0);
      reset = 1'b1;
      #1;
      chk("mid_valid",     {31'd0, valid},    32'd0);
      chk("mid_ready",     {31'd0, ready},    32'd1);
      chk("mid_error",     {31'd0, error},    32'd0);
      chk("mid_overflow",  {31'd0, overflow}, 32'd0);
      chk("mid_quotient",  quotient,          32'd0);
      chk("mid_remainder", remainder,         32'd0);
      chk("mid_tag_out",   {28'd0, tag_out},  32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_vec(vecs[0], 100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
      $finish;
   end

endmodule
